// File: rtl/iobus_pkg.sv
// Shared types and constants for the pad bus controller.
package iobus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_TURN   = 3'd1,
    WR_DRIVE  = 3'd2,
    WR_REL    = 3'd3,
    RD_SETTLE = 3'd4,
    RD_CAP    = 3'd5
  } state_t;

  // IOBUF T polarity: high means the buffer is tri-stated.
  localparam logic PAD_HIZ = 1'b1;
  localparam logic PAD_DRV = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iobus_arb.sv
// Two-way grant logic for the pad bus (write vs read requester).
// Build option IOBUS_RR_EN: round-robin arbitration using a last-grant flop;
// without it, writes have fixed priority and the block is purely combinational.
module iobus_arb
  import iobus_pkg::*;
(
`ifdef IOBUS_RR_EN
  input  logic clk,
  input  logic reset_n,
`endif
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic gnt_wr,
  output logic gnt_rd
);

`ifdef IOBUS_RR_EN
  // last_rd = 1 when the read requester was served most recently
  logic last_rd;

  // on a conflict, serve whichever requester was not served last
  always_comb begin
    gnt_wr = en & wr_req & (~rd_req | last_rd);
    gnt_rd = en & rd_req & (~wr_req | ~last_rd);
  end

  // remember the most recent grant, contested or not; reset favours write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_rd <= 1'b1;
    else if (gnt_wr) last_rd <= 1'b0;
    else if (gnt_rd) last_rd <= 1'b1;
  end
`else
  // fixed priority: write wins on simultaneous requests
  always_comb begin
    gnt_wr = en & wr_req;
    gnt_rd = en & rd_req & ~wr_req;
  end
`endif

endmodule

// File: rtl/iobuf_bus_ctrl.sv
// Sequencer for a bank of tri-state IOBUFs forming one shared pad bus.
// Inserts high-Z turnaround before every drive and a settle gap before every
// read capture. All outputs come straight from flops.
// Build option IOBUS_RR_EN selects round-robin arbitration (see iobus_arb).
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | bus high-Z, waiting for a request
// WR_TURN   | high-Z turnaround, pad_i already holds write data
// WR_DRIVE  | pad_t low, bus driven with pad_i
// WR_REL    | bus released, wr_ack pulse
// RD_SETTLE | high-Z settle before capture
// RD_CAP    | rd_data captured from pad_o, rd_valid pulse
module iobuf_bus_ctrl
  import iobus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TURN      = 2,
  parameter int DRIVE_CYC = 3,
  parameter int SETTLE    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             pad_t,
  output logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] pad_o
);

  localparam int MAXC = max3(TURN, DRIVE_CYC, SETTLE);
  localparam int CW   = $clog2(MAXC + 1);

  // down-counter reload values: a phase of N cycles loads N-1 and ends at zero
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN - 1);
  localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt_wr, gnt_rd;

  logic             pad_t_d, wr_ack_d, rd_valid_d, busy_d;
  logic [WIDTH-1:0] pad_i_d, rd_data_d;

  iobus_arb u_arb (
`ifdef IOBUS_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .en      (state_q == IDLE),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .gnt_wr  (gnt_wr),
    .gnt_rd  (gnt_rd)
  );

  // state, counter and registered outputs; reset releases the bus at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pad_t    <= PAD_HIZ;
      pad_i    <= '0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pad_t    <= pad_t_d;
      pad_i    <= pad_i_d;
      wr_ack   <= wr_ack_d;
      rd_valid <= rd_valid_d;
      rd_data  <= rd_data_d;
      busy     <= busy_d;
    end
  end

  // next state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_wr) begin
          state_d = WR_TURN;
          cnt_d   = TURN_LD;
        end else if (gnt_rd) begin
          state_d = RD_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      WR_TURN: begin
        if (cnt_q == '0) begin
          state_d = WR_DRIVE;
          cnt_d   = DRIVE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_DRIVE: begin
        if (cnt_q == '0) state_d = WR_REL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_REL: state_d = IDLE;
      RD_SETTLE: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_CAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs decoded from the upcoming state so they land with it in the flops
  always_comb begin
    pad_t_d    = (state_d == WR_DRIVE) ? PAD_DRV : PAD_HIZ;
    wr_ack_d   = (state_d == WR_REL);
    rd_valid_d = (state_d == RD_CAP);
    busy_d     = (state_d != IDLE);
    // pad_i only moves on a write grant, which is always a high-Z cycle
    pad_i_d    = gnt_wr ? wr_data : pad_i;
    rd_data_d  = (state_d == RD_CAP) ? pad_o : rd_data;
  end

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Directed self-checking bench for iobuf_bus_ctrl (WIDTH=8, TURN=2,
// DRIVE_CYC=3, SETTLE=2). Expected arbitration order follows IOBUS_RR_EN.
module tb_iobuf_bus_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       pad_t;
  logic [7:0] pad_i;
  logic [7:0] pad_o;

  int n_cmp = 0;
  int n_bad = 0;

  iobuf_bus_ctrl #(.WIDTH(8), .TURN(2), .DRIVE_CYC(3), .SETTLE(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .pad_t    (pad_t),
    .pad_i    (pad_i),
    .pad_o    (pad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = 8'h00;
    pad_o   = 8'h00;
    repeat (3) tick();
    n_cmp++; if (pad_t !== 1'b1)   begin n_bad++; $display("FAIL reset_pad_t got=%b exp=1", pad_t); end
    n_cmp++; if (pad_i !== 8'h00)  begin n_bad++; $display("FAIL reset_pad_i got=%h exp=00", pad_i); end
    n_cmp++; if (wr_ack !== 1'b0)  begin n_bad++; $display("FAIL reset_wr_ack got=%b exp=0", wr_ack); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  // cycle c = c-th clock after the grant edge
  task automatic test_write();
    logic exp_t;
    wr_data = 8'hA5;
    wr_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_t = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      n_cmp++; if (pad_t !== exp_t) begin n_bad++; $display("FAIL write_pad_t c=%0d got=%b exp=%b", c, pad_t, exp_t); end
      n_cmp++; if (wr_ack !== (c == 6)) begin n_bad++; $display("FAIL write_ack c=%0d got=%b exp=%b", c, wr_ack, (c == 6)); end
      n_cmp++; if (busy !== (c <= 6)) begin n_bad++; $display("FAIL write_busy c=%0d got=%b exp=%b", c, busy, (c <= 6)); end
      n_cmp++; if (pad_i !== 8'hA5) begin n_bad++; $display("FAIL write_pad_i c=%0d got=%h exp=a5", c, pad_i); end
      if (wr_ack) wr_req = 1'b0;
    end
    wr_req = 1'b0;
  endtask

  task automatic test_read();
    pad_o  = 8'h3C;
    rd_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_cmp++; if (pad_t !== 1'b1) begin n_bad++; $display("FAIL read_pad_t c=%0d got=%b exp=1", c, pad_t); end
      n_cmp++; if (rd_valid !== (c == 3)) begin n_bad++; $display("FAIL read_valid c=%0d got=%b exp=%b", c, rd_valid, (c == 3)); end
      n_cmp++; if (rd_data !== ((c >= 3) ? 8'h3C : 8'h00)) begin n_bad++; $display("FAIL read_data c=%0d got=%h exp=%h", c, rd_data, ((c >= 3) ? 8'h3C : 8'h00)); end
      n_cmp++; if (busy !== (c <= 3)) begin n_bad++; $display("FAIL read_busy c=%0d got=%b exp=%b", c, busy, (c <= 3)); end
      if (rd_valid) rd_req = 1'b0;
      if (c == 4) pad_o = 8'h55;
    end
    rd_req = 1'b0;
  endtask

  // both requests raised together; with rearm the writer re-requests right
  // after its first ack while the reader is still waiting (second conflict)
  task automatic run_conflict(input string name, input bit rearm, input int n_exp,
                              input byte e0, input byte e1, input byte e2);
    byte ord [0:7];
    byte exp_ord [0:2];
    int  n;
    bit  rearm_now;
    bit  used;
    exp_ord[0] = e0; exp_ord[1] = e1; exp_ord[2] = e2;
    n = 0; rearm_now = 1'b0; used = 1'b0;
    wr_data = 8'h11;
    pad_o   = 8'h22;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    for (int k = 0; k < 80 && n < n_exp; k++) begin
      tick();
      if (rearm_now) begin
        wr_req    = 1'b1;
        wr_data   = 8'h33;
        rearm_now = 1'b0;
      end
      if (wr_ack) begin
        if (n < 8) ord[n] = "W";
        n++;
        wr_req = 1'b0;
        if (rearm && !used) begin rearm_now = 1'b1; used = 1'b1; end
      end
      if (rd_valid) begin
        if (n < 8) ord[n] = "R";
        n++;
        rd_req = 1'b0;
        n_cmp++; if (rd_data !== 8'h22) begin n_bad++; $display("FAIL %s rd_data got=%h exp=22", name, rd_data); end
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    n_cmp++;
    if (n != n_exp) begin
      n_bad++;
      $display("FAIL %s completions got=%0d exp=%0d (cycle budget)", name, n, n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        n_cmp++;
        if (ord[i] !== exp_ord[i]) begin
          n_bad++;
          $display("FAIL %s order[%0d] got=%c exp=%c", name, i, ord[i], exp_ord[i]);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_conflict();
`ifdef IOBUS_RR_EN
    run_conflict("conflict_rearm", 1'b1, 3, "W", "R", "W");
    run_conflict("conflict_plain", 1'b0, 2, "R", "W", "-");
`else
    run_conflict("conflict_rearm", 1'b1, 3, "W", "W", "R");
    run_conflict("conflict_plain", 1'b0, 2, "W", "R", "-");
`endif
  endtask

  task automatic test_reset_mid();
    wr_data = 8'hC3;
    wr_req  = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    n_cmp++; if (pad_t !== 1'b0) begin n_bad++; $display("FAIL rstmid_driving got=%b exp=0", pad_t); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (pad_t !== 1'b1) begin n_bad++; $display("FAIL rstmid_async_pad_t got=%b exp=1", pad_t); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (pad_i !== 8'h00) begin n_bad++; $display("FAIL rstmid_pad_i got=%h exp=00", pad_i); end
    wr_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_ack c=%0d got=%b exp=0", c, wr_ack); end
      n_cmp++; if (pad_t !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle_pad_t c=%0d got=%b exp=1", c, pad_t); end
    end
    pad_o  = 8'h5A;
    rd_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if (rd_valid !== (c == 3)) begin n_bad++; $display("FAIL rstmid_read_valid c=%0d got=%b exp=%b", c, rd_valid, (c == 3)); end
      if (c == 3) begin
        n_cmp++; if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL rstmid_read_data got=%h exp=5a", rd_data); end
      end
      if (rd_valid) rd_req = 1'b0;
    end
    rd_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic       prev_t;
    logic [7:0] prev_i;
    int nwin, acks, gap, hiz_run, dl, len1, len2;
    bit rearm_now;
    prev_t = pad_t; prev_i = pad_i;
    nwin = 0; acks = 0; gap = -1; hiz_run = 0; dl = 0; len1 = -1; len2 = -1;
    rearm_now = 1'b0;
    wr_data = 8'h01;
    wr_req  = 1'b1;
    for (int k = 0; k < 40 && acks < 2; k++) begin
      tick();
      if (rearm_now) begin
        wr_data   = 8'h02;
        wr_req    = 1'b1;
        rearm_now = 1'b0;
      end
      if (pad_i !== prev_i) begin
        n_cmp++; if (pad_t !== 1'b1) begin n_bad++; $display("FAIL b2b_pad_i_change_while_driving got=%b exp=1", pad_t); end
        prev_i = pad_i;
      end
      if (pad_t == 1'b0) begin
        if (prev_t == 1'b1) begin
          nwin++;
          if (nwin == 2) gap = hiz_run;
          dl = 0;
        end
        dl++;
        n_cmp++; if (pad_i !== ((nwin == 1) ? 8'h01 : 8'h02)) begin n_bad++; $display("FAIL b2b_drive_data win=%0d got=%h exp=%h", nwin, pad_i, ((nwin == 1) ? 8'h01 : 8'h02)); end
      end else begin
        if (prev_t == 1'b0) begin
          if (nwin == 1) len1 = dl;
          if (nwin == 2) len2 = dl;
          hiz_run = 0;
        end
        hiz_run++;
      end
      prev_t = pad_t;
      if (wr_ack) begin
        acks++;
        wr_req = 1'b0;
        if (acks == 1) rearm_now = 1'b1;
      end
    end
    wr_req = 1'b0;
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
    n_cmp++; if (nwin != 2) begin n_bad++; $display("FAIL b2b_windows got=%0d exp=2", nwin); end
    n_cmp++; if (gap != 4)  begin n_bad++; $display("FAIL b2b_gap got=%0d exp=4", gap); end
    n_cmp++; if (len1 != 3) begin n_bad++; $display("FAIL b2b_len1 got=%0d exp=3", len1); end
    n_cmp++; if (len2 != 3) begin n_bad++; $display("FAIL b2b_len2 got=%0d exp=3", len2); end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
